// File: rtl/command_serializer.sv
// Host-side framer: takes one parallel command per handshake and writes its byte frame
// (opcode, then the block/reg/data/instr fields the opcode selects) into the command FIFO.
module command_serializer #(
  parameter int unsigned n_blocks             = 32,
  parameter int unsigned n_block_registers    = 16,
  parameter int unsigned data_width           = 16,
  parameter int unsigned BLOCK_REG_ADDR_WIDTH = $clog2(n_block_registers),
  parameter int unsigned BLOCK_INSTR_WIDTH    = 32,
  localparam int unsigned BW                  = $clog2(n_blocks)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [7:0]                      cmd_opcode,
  input  logic [BW-1:0]                   cmd_block,
  input  logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg,
  input  logic [data_width-1:0]           cmd_data,
  input  logic [BLOCK_INSTR_WIDTH-1:0]    cmd_instr,
  output logic [7:0]                      out_byte,
  output logic                            out_write,
  input  logic                            out_full,
  output logic                            busy,
  output logic                            invalid
);

  // Opcode bits [7:4] flag the block, reg, data and instr fields respectively.
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR = 8'h91;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG   = 8'hE2;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG  = 8'hE3;
  localparam logic [7:0] COMMAND_ALLOC_SRAM_DELAY  = 8'hA4;

  localparam int unsigned BB        = (BW / 8 > 1) ? BW / 8 : 1;
  localparam int unsigned DB        = data_width / 8;
  localparam int unsigned IB        = BLOCK_INSTR_WIDTH / 8;
  localparam int unsigned BlkBits   = BB * 8;
  localparam int unsigned DataBits  = DB * 8;
  localparam int unsigned InstrBits = IB * 8;
  localparam int unsigned MaxB0     = (BB > DB) ? BB : DB;
  localparam int unsigned MaxB      = (MaxB0 > IB) ? MaxB0 : IB;
  localparam int unsigned CntW      = $clog2(MaxB + 1);

  typedef enum logic [2:0] {StIdle, StOpcode, StBlock, StReg, StData, StInstr} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            op_q, op_d;
  logic [BlkBits-1:0]    blk_q, blk_d;
  logic [7:0]            reg_q, reg_d;
  logic [DataBits-1:0]   data_q, data_d;
  logic [InstrBits-1:0]  instr_q, instr_d;
  logic [3:0]            has_q, has_d;  // {block, reg, data, instr}
  logic                  invalid_q, invalid_d;

  logic   opcode_ok;
  state_e after_op, after_blk, after_reg, after_data;

  assign opcode_ok = (cmd_opcode == COMMAND_WRITE_BLOCK_INSTR) ||
                     (cmd_opcode == COMMAND_WRITE_BLOCK_REG)   ||
                     (cmd_opcode == COMMAND_UPDATE_BLOCK_REG)  ||
                     (cmd_opcode == COMMAND_ALLOC_SRAM_DELAY);

  assign after_data = has_q[0] ? StInstr : StIdle;
  assign after_reg  = has_q[1] ? StData  : after_data;
  assign after_blk  = has_q[2] ? StReg   : after_reg;
  assign after_op   = has_q[3] ? StBlock : after_blk;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_write = (state_q != StIdle) & ~out_full;
  assign invalid   = invalid_q;

  always_comb begin
    out_byte = 8'h00;
    unique case (state_q)
      StOpcode: out_byte = op_q;
      StBlock:  out_byte = blk_q[BlkBits-1 -: 8];
      StReg:    out_byte = reg_q;
      StData:   out_byte = data_q[DataBits-1 -: 8];
      StInstr:  out_byte = instr_q[InstrBits-1 -: 8];
      default:  out_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    blk_d     = blk_q;
    reg_d     = reg_q;
    data_d    = data_q;
    instr_d   = instr_q;
    has_d     = has_q;
    invalid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (opcode_ok) begin
            op_d    = cmd_opcode;
            blk_d   = BlkBits'(cmd_block);
            reg_d   = 8'(cmd_reg);
            data_d  = DataBits'(cmd_data);
            instr_d = InstrBits'(cmd_instr);
            has_d   = cmd_opcode[7:4];
            cnt_d   = '0;
            state_d = StOpcode;
          end else begin
            invalid_d = 1'b1;
          end
        end
      end
      StOpcode: if (out_write) state_d = after_op;
      StBlock: begin
        if (out_write) begin
          blk_d = blk_q << 8;
          if (cnt_q == CntW'(BB - 1)) begin
            cnt_d   = '0;
            state_d = after_blk;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StReg: if (out_write) state_d = after_reg;
      StData: begin
        if (out_write) begin
          data_d = data_q << 8;
          if (cnt_q == CntW'(DB - 1)) begin
            cnt_d   = '0;
            state_d = after_data;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StInstr: begin
        if (out_write) begin
          instr_d = instr_q << 8;
          if (cnt_q == CntW'(IB - 1)) begin
            cnt_d   = '0;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= '0;
      blk_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      instr_q   <= '0;
      has_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      blk_q     <= blk_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      instr_q   <= instr_d;
      has_q     <= has_d;
      invalid_q <= invalid_d;
    end
  end

endmodule

// File: tb/tb_command_serializer.sv
// Directed and random stimulus for command_serializer; emitted bytes are checked against
// a queue of expected frame bytes filled when each command is driven.
module tb_command_serializer;

  localparam logic [7:0] OP_WBI   = 8'h91;
  localparam logic [7:0] OP_WBR   = 8'hE2;
  localparam logic [7:0] OP_UBR   = 8'hE3;
  localparam logic [7:0] OP_ALLOC = 8'hA4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = 8'h00;
  logic [4:0]  cmd_block = '0;
  logic [3:0]  cmd_reg = '0;
  logic [15:0] cmd_data = '0;
  logic [31:0] cmd_instr = '0;
  logic [7:0]  out_byte;
  logic        out_write;
  logic        out_full = 1'b0;
  logic        busy;
  logic        invalid;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int inv_count = 0;
  logic [7:0] exp_q[$];

  command_serializer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_block  (cmd_block),
    .cmd_reg    (cmd_reg),
    .cmd_data   (cmd_data),
    .cmd_instr  (cmd_instr),
    .out_byte   (out_byte),
    .out_write  (out_write),
    .out_full   (out_full),
    .busy       (busy),
    .invalid    (invalid)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Every FIFO write is matched against the head of the expected-byte queue.
  always @(negedge clk) begin
    if (reset && invalid) inv_count++;
    if (reset && out_write) begin
      wr_count++;
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("frame_byte", {24'h0, out_byte}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic push_frame(input logic [7:0] op, input logic [4:0] blk, input logic [3:0] rg,
                            input logic [15:0] data, input logic [31:0] instr);
    exp_q.push_back(op);
    if (op[7]) exp_q.push_back({3'b000, blk});
    if (op[6]) exp_q.push_back({4'h0, rg});
    if (op[5]) begin
      exp_q.push_back(data[15:8]);
      exp_q.push_back(data[7:0]);
    end
    if (op[4]) begin
      exp_q.push_back(instr[31:24]);
      exp_q.push_back(instr[23:16]);
      exp_q.push_back(instr[15:8]);
      exp_q.push_back(instr[7:0]);
    end
  endtask

  // Returns at #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [4:0] blk, input logic [3:0] rg,
                      input logic [15:0] data, input logic [31:0] instr, input bit is_valid);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_block  = blk;
    cmd_reg    = rg;
    cmd_data   = data;
    cmd_instr  = instr;
    if (is_valid) push_frame(op, blk, rg, data, instr);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_opcode = 8'($urandom);
    cmd_block  = 5'($urandom);
    cmd_reg    = 4'($urandom);
    cmd_data   = 16'($urandom);
    cmd_instr  = $urandom;
  endtask

  task automatic wait_idle(input bit rand_full);
    int n = 0;
    while (!cmd_ready && n < 500) begin
      if (rand_full) out_full = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      n++;
    end
    out_full = 1'b0;
    chk("idle_timeout", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int w0;
    int i0;
    logic [7:0] ops[4];
    logic [7:0] bad_ops[3];
    ops     = '{OP_WBI, OP_WBR, OP_UBR, OP_ALLOC};
    bad_ops = '{8'h00, 8'hFF, 8'hE0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(out_write), 32'd0);
    chk("rst_invalid", 32'(invalid), 32'd0);
    chk("rst_byte", {24'h0, out_byte}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Register write, no backpressure: 5 bytes back to back, ready after the 5th edge
    w0 = wr_count;
    send(OP_WBR, 5'd3, 4'hA, 16'hBEEF, 32'h0, 1'b1);
    chk("wbr_busy", 32'(busy), 32'd1);
    chk("wbr_first_byte", {24'h0, out_byte}, {24'h0, OP_WBR});
    repeat (4) begin
      @(posedge clk); #1;
      chk("wbr_ready_low", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("wbr_ready_high", 32'(cmd_ready), 32'd1);
    chk("wbr_writes", 32'(wr_count - w0), 32'd5);

    // Block instruction write; cmd_valid held with another opcode while busy
    w0 = wr_count;
    send(OP_WBI, 5'd31, 4'h0, 16'h0, 32'h12345678, 1'b1);
    cmd_valid  = 1'b1;
    cmd_opcode = OP_ALLOC;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle(1'b0);
    chk("wbi_writes", 32'(wr_count - w0), 32'd6);
    chk("wbi_drained", 32'(exp_q.size()), 32'd0);

    // Stall for 5 cycles after the register byte
    w0 = wr_count;
    send(OP_WBR, 5'd3, 4'hA, 16'hBEEF, 32'h0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_write", 32'(out_write), 32'd0);
      chk("stall_byte", {24'h0, out_byte}, 32'hBE);
      @(posedge clk); #1;
    end
    out_full = 1'b0;
    @(posedge clk); #1;
    chk("stall_ready_low", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    chk("stall_ready_high", 32'(cmd_ready), 32'd1);
    chk("stall_writes", 32'(wr_count - w0), 32'd5);

    // Unknown opcodes are dropped with a one-cycle invalid pulse
    for (int k = 0; k < 3; k++) begin
      w0 = wr_count;
      i0 = inv_count;
      send(bad_ops[k], 5'd7, 4'h3, 16'h1234, 32'hCAFE0001, 1'b0);
      chk("inv_pulse", 32'(invalid), 32'd1);
      chk("inv_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      chk("inv_pulse_end", 32'(invalid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("inv_count", 32'(inv_count - i0), 32'd1);
      chk("inv_no_write", 32'(wr_count - w0), 32'd0);
    end

    // Reset after the second byte aborts the frame at once
    send(OP_WBR, 5'd9, 4'h5, 16'h0F0F, 32'h0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_write", 32'(out_write), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(negedge clk); #1;
    reset = 1'b1;
    w0 = wr_count;
    send(OP_UBR, 5'd17, 4'hC, 16'h8001, 32'h0, 1'b1);
    wait_idle(1'b0);
    chk("post_abort_writes", 32'(wr_count - w0), 32'd5);
    chk("post_abort_drained", 32'(exp_q.size()), 32'd0);

    // Random valid commands under random backpressure
    i0 = inv_count;
    for (int k = 0; k < 60; k++) begin
      send(ops[$urandom_range(0, 3)], 5'($urandom), 4'($urandom), 16'($urandom), $urandom, 1'b1);
      wait_idle(1'b1);
    end
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_no_invalid", 32'(inv_count - i0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
